// File: rtl/uart_debug_unit.sv
// uart_debug_unit: host debug protocol responder for the MIPS core.
// Receives command/data bytes from the UART receiver, loads instruction
// memory, controls run/step mode and streams register-file and pipeline
// latch dumps back through the UART transmitter.
module uart_debug_unit #(
   parameter int unsigned SIZE            = 32,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MAX_INSTRUCTION = 64,
   parameter int unsigned NUM_REGISTERS   = 32,
   parameter int unsigned IF_ID_SIZE      = 32,
   parameter int unsigned ID_EX_SIZE      = 129,
   parameter int unsigned EX_MEM_SIZE     = 77,
   parameter int unsigned MEM_WB_SIZE     = 71,
   parameter int unsigned CMD_FIFO_DEPTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_imem_we,
   output logic [ADDR_WIDTH-1:0]  o_imem_addr,
   output logic [SIZE-1:0]        o_imem_data,
   output logic [4:0]             o_reg_addr,
   input  logic [SIZE-1:0]        i_reg_data,
   input  logic [IF_ID_SIZE-1:0]  i_if_id,
   input  logic [ID_EX_SIZE-1:0]  i_id_ex,
   input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
   input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
   input  logic                   i_halt,
   output logic                   o_run,
   output logic                   o_step,
   output logic                   o_cpu_rst,
   output logic                   o_mode_step
);

   localparam int unsigned FIFO_AW     = $clog2(CMD_FIFO_DEPTH);
   localparam int unsigned IF_ID_B     = (IF_ID_SIZE + 7) / 8;
   localparam int unsigned ID_EX_B     = (ID_EX_SIZE + 7) / 8;
   localparam int unsigned EX_MEM_B    = (EX_MEM_SIZE + 7) / 8;
   localparam int unsigned MEM_WB_B    = (MEM_WB_SIZE + 7) / 8;
   localparam int unsigned SNAP_B_A    = (IF_ID_B > ID_EX_B) ? IF_ID_B : ID_EX_B;
   localparam int unsigned SNAP_B_B    = (EX_MEM_B > MEM_WB_B) ? EX_MEM_B : MEM_WB_B;
   localparam int unsigned SNAP_BYTES  = (SNAP_B_A > SNAP_B_B) ? SNAP_B_A : SNAP_B_B;
   localparam int unsigned SNAP_W      = SNAP_BYTES * 8;
   localparam int unsigned REG_BYTES   = 4 * NUM_REGISTERS;
   localparam int unsigned MAX_BYTES   = (REG_BYTES > SNAP_BYTES) ? REG_BYTES : SNAP_BYTES;
   localparam int unsigned CNT_W       = $clog2(MAX_BYTES + 1);
   localparam int unsigned WCNT_W      = $clog2(MAX_INSTRUCTION + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, DUMP_SETUP, DUMP_TX, DUMP_WAIT
   } state_e;

   typedef enum logic [2:0] {
      DK_REG, DK_IFID, DK_IDEX, DK_EXMEM, DK_MEMWB
   } dump_kind_e;

   state_e                state_q, state_d;
   dump_kind_e            kind_q;
   logic [7:0]            fifo_q [CMD_FIFO_DEPTH];
   logic [FIFO_AW:0]      wr_ptr_q, rd_ptr_q;
   logic                  fifo_empty, fifo_full;
   logic [7:0]            cmd;
   logic                  push, pop, load_take;
   logic [WCNT_W-1:0]     word_cnt_q;
   logic [1:0]            byte_idx_q;
   logic [23:0]           word_buf_q;
   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [SIZE-1:0]       imem_data_q;
   logic [SNAP_W-1:0]     snap_q;
   logic [CNT_W-1:0]      dump_idx_q, dump_len_q;
   logic                  last_byte;
   logic [7:0]            tx_byte;
   logic [7:0]            tx_data_q;
   logic                  tx_start_q;
   logic                  mode_step_q, running_q, step_q, cpu_rst_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign cmd        = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
   assign last_byte  = (dump_idx_q == dump_len_q - CNT_W'(1));

   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_imem_we   = imem_we_q;
   assign o_imem_addr = imem_addr_q;
   assign o_imem_data = imem_data_q;
   assign o_reg_addr  = 5'(dump_idx_q >> 2);
   assign o_run       = running_q & ~mode_step_q;
   assign o_step      = step_q;
   assign o_cpu_rst   = cpu_rst_q;
   assign o_mode_step = mode_step_q;

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (cmd == 8'h02)                        state_d = LOAD;
               else if (cmd >= 8'h03 && cmd <= 8'h07)   state_d = DUMP_SETUP;
            end
         end
         LOAD: begin
            if (i_rx_valid) begin
               if (byte_idx_q == 2'd0 && i_rx_data == 8'h0C)
                  state_d = IDLE;
               else if (byte_idx_q == 2'd3 &&
                        word_cnt_q == WCNT_W'(MAX_INSTRUCTION - 1))
                  state_d = IDLE;
            end
         end
         DUMP_SETUP: state_d = DUMP_TX;
         DUMP_TX:    state_d = DUMP_WAIT;
         DUMP_WAIT: begin
            if (i_tx_done) state_d = last_byte ? IDLE : DUMP_TX;
         end
         default:    state_d = IDLE;
      endcase
   end

   // FSM output decode: FIFO strobes, load strobe and outgoing byte select
   always_comb begin
      push      = i_rx_valid && (state_q != LOAD) && !fifo_full;
      pop       = (state_q == IDLE) && !fifo_empty;
      load_take = (state_q == LOAD) && i_rx_valid &&
                  !(byte_idx_q == 2'd0 && i_rx_data == 8'h0C);
      tx_byte   = snap_q[7:0];
      if (kind_q == DK_REG) begin
         unique case (dump_idx_q[1:0])
            2'd0: tx_byte = i_reg_data[7:0];
            2'd1: tx_byte = i_reg_data[15:8];
            2'd2: tx_byte = i_reg_data[23:16];
            2'd3: tx_byte = i_reg_data[31:24];
         endcase
      end
   end

   // Command FIFO storage (contents are don't-care while empty)
   always_ff @(posedge i_clk) begin
      if (push) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= i_rx_data;
   end

   // Datapath: FIFO pointers, command execution, program loader, dump engine
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         kind_q      <= DK_REG;
         word_cnt_q  <= '0;
         byte_idx_q  <= '0;
         word_buf_q  <= '0;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         snap_q      <= '0;
         dump_idx_q  <= '0;
         dump_len_q  <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         mode_step_q <= 1'b0;
         running_q   <= 1'b0;
         step_q      <= 1'b0;
         cpu_rst_q   <= 1'b0;
      end else begin
         imem_we_q  <= 1'b0;
         tx_start_q <= 1'b0;
         step_q     <= 1'b0;
         cpu_rst_q  <= 1'b0;

         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            case (cmd)
               8'h02: begin
                  word_cnt_q <= '0;
                  byte_idx_q <= '0;
               end
               8'h03: kind_q      <= DK_REG;
               8'h04: kind_q      <= DK_IFID;
               8'h05: kind_q      <= DK_IDEX;
               8'h06: kind_q      <= DK_EXMEM;
               8'h07: kind_q      <= DK_MEMWB;
               8'h08: mode_step_q <= 1'b0;
               8'h09: mode_step_q <= 1'b1;
               8'h0A: step_q      <= running_q & mode_step_q;
               8'h0D: cpu_rst_q   <= 1'b1;
               default: ;
            endcase
         end

         // Restart follows the reset pulse by one cycle and overrides a halt.
         if (cpu_rst_q)   running_q <= 1'b1;
         else if (i_halt) running_q <= 1'b0;

         if (load_take) begin
            byte_idx_q <= byte_idx_q + 1'b1;
            unique case (byte_idx_q)
               2'd0: word_buf_q[7:0]   <= i_rx_data;
               2'd1: word_buf_q[15:8]  <= i_rx_data;
               2'd2: word_buf_q[23:16] <= i_rx_data;
               2'd3: begin
                  imem_we_q   <= 1'b1;
                  imem_addr_q <= ADDR_WIDTH'({word_cnt_q, 2'b00});
                  imem_data_q <= SIZE'({i_rx_data, word_buf_q});
                  word_cnt_q  <= word_cnt_q + 1'b1;
               end
            endcase
         end

         if (state_q == DUMP_SETUP) begin
            dump_idx_q <= '0;
            unique case (kind_q)
               DK_REG:   begin snap_q <= '0;                 dump_len_q <= CNT_W'(REG_BYTES); end
               DK_IFID:  begin snap_q <= SNAP_W'(i_if_id);   dump_len_q <= CNT_W'(IF_ID_B);   end
               DK_IDEX:  begin snap_q <= SNAP_W'(i_id_ex);   dump_len_q <= CNT_W'(ID_EX_B);   end
               DK_EXMEM: begin snap_q <= SNAP_W'(i_ex_mem);  dump_len_q <= CNT_W'(EX_MEM_B);  end
               DK_MEMWB: begin snap_q <= SNAP_W'(i_mem_wb);  dump_len_q <= CNT_W'(MEM_WB_B);  end
               default:  begin snap_q <= '0;                 dump_len_q <= '0;                end
            endcase
         end

         if (state_q == DUMP_TX) begin
            tx_data_q  <= tx_byte;
            tx_start_q <= 1'b1;
         end

         // The snapshot shifts down so the next latch byte is always in [7:0].
         if (state_q == DUMP_WAIT && i_tx_done) begin
            dump_idx_q <= dump_idx_q + 1'b1;
            snap_q     <= snap_q >> 8;
         end
      end
   end

endmodule

// File: tb/tb_uart_debug_unit.sv
// Directed testbench for uart_debug_unit.
module tb_uart_debug_unit;

   logic         i_clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         rx_valid = 1'b0;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         tx_done = 1'b0;
   logic         imem_we;
   logic [31:0]  imem_addr;
   logic [31:0]  imem_data;
   logic [4:0]   reg_addr;
   logic [31:0]  reg_data;
   logic [31:0]  if_id = '0;
   logic [128:0] id_ex = '0;
   logic [76:0]  ex_mem = '0;
   logic [70:0]  mem_wb = '0;
   logic         halt = 1'b0;
   logic         run, step, cpu_rst, mode_step;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int step_cnt  = 0;
   int cpu_rst_cnt = 0;
   logic [7:0]  tx_q[$];
   logic [31:0] we_addr_q[$];
   logic [31:0] we_data_q[$];

   always #5 i_clk = ~i_clk;

   // Register file model: register k holds k * 0x01010101
   assign reg_data = {3'b000, reg_addr, 3'b000, reg_addr, 3'b000, reg_addr, 3'b000, reg_addr};

   uart_debug_unit #(
      .SIZE(32), .ADDR_WIDTH(32), .MAX_INSTRUCTION(64), .NUM_REGISTERS(32),
      .IF_ID_SIZE(32), .ID_EX_SIZE(129), .EX_MEM_SIZE(77), .MEM_WB_SIZE(71),
      .CMD_FIFO_DEPTH(4)
   ) dut (
      .i_clk(i_clk), .i_rst(rst_n),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
      .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
      .o_reg_addr(reg_addr), .i_reg_data(reg_data),
      .i_if_id(if_id), .i_id_ex(id_ex), .i_ex_mem(ex_mem), .i_mem_wb(mem_wb),
      .i_halt(halt), .o_run(run), .o_step(step), .o_cpu_rst(cpu_rst),
      .o_mode_step(mode_step)
   );

   // Output monitor, sampled on the falling edge
   always @(negedge i_clk) begin
      if (tx_start) tx_q.push_back(tx_data);
      if (imem_we) begin
         we_addr_q.push_back(imem_addr);
         we_data_q.push_back(imem_data);
      end
      if (step) step_cnt++;
      if (cpu_rst) cpu_rst_cnt++;
   end

   // UART transmitter model: byte completes a few cycles after start
   always begin
      @(negedge i_clk);
      if (tx_start) begin
         repeat (3) @(posedge i_clk);
         #1 tx_done = 1'b1;
         @(posedge i_clk);
         #1 tx_done = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge i_clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge i_clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      for (int c = 0; c < budget && tx_q.size() < n; c++) @(posedge i_clk);
      idle(60);
   endtask

   task automatic test_reset();
      idle(3);
      total_cnt++;
      if ({tx_start, imem_we, run, step, cpu_rst, mode_step} !== 6'b0) $display("FAIL reset_strobes got=%b exp=000000", {tx_start, imem_we, run, step, cpu_rst, mode_step});
      else pass_cnt++;
      total_cnt++;
      if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data);
      else pass_cnt++;
      total_cnt++;
      if (reg_addr !== 5'd0 || imem_addr !== 32'd0 || imem_data !== 32'd0) $display("FAIL reset_addr got=%h/%h/%h exp=0", reg_addr, imem_addr, imem_data);
      else pass_cnt++;
      rst_n = 1'b1;
      idle(2);
      total_cnt++;
      if (run !== 1'b0 || mode_step !== 1'b0) $display("FAIL post_reset_run got=%b%b exp=00", run, mode_step);
      else pass_cnt++;
   endtask

   task automatic test_mode();
      send_byte(8'h09);
      idle(3);
      total_cnt++;
      if (mode_step !== 1'b1) $display("FAIL mode_step_set got=%b exp=1", mode_step);
      else pass_cnt++;
      send_byte(8'h08);
      idle(3);
      total_cnt++;
      if (mode_step !== 1'b0) $display("FAIL mode_step_clr got=%b exp=0", mode_step);
      else pass_cnt++;
      cpu_rst_cnt = 0;
      send_byte(8'h0D);
      @(posedge i_clk); #1;
      total_cnt++;
      if (cpu_rst !== 1'b1 || run !== 1'b0) $display("FAIL cpu_rst_pulse got=%b%b exp=10", cpu_rst, run);
      else pass_cnt++;
      @(posedge i_clk); #1;
      total_cnt++;
      if (cpu_rst !== 1'b0 || run !== 1'b1) $display("FAIL run_after_rst got=%b%b exp=01", cpu_rst, run);
      else pass_cnt++;
      idle(4);
      total_cnt++;
      if (cpu_rst_cnt !== 1) $display("FAIL cpu_rst_count got=%0d exp=1", cpu_rst_cnt);
      else pass_cnt++;
   endtask

   task automatic test_load();
      logic [7:0] prog [12] = '{8'h03, 8'h00, 8'h01, 8'h3C, 8'h01, 8'h00, 8'h02, 8'h3C,
                                8'h21, 8'h18, 8'h22, 8'h00};
      logic [31:0] exp_data [3] = '{32'h3C010003, 32'h3C020001, 32'h00221821};
      we_addr_q.delete(); we_data_q.delete();
      send_byte(8'h02);
      idle(2);
      for (int i = 0; i < 12; i++) send_byte(prog[i]);
      send_byte(8'h0C);
      idle(3);
      total_cnt++;
      if (we_addr_q.size() !== 3) $display("FAIL load_we_count got=%0d exp=3", we_addr_q.size());
      else pass_cnt++;
      for (int i = 0; i < 3 && i < we_addr_q.size(); i++) begin
         total_cnt++;
         if (we_addr_q[i] !== 32'(i * 4) || we_data_q[i] !== exp_data[i])
            $display("FAIL load_word%0d got=%h:%h exp=%h:%h", i, we_addr_q[i], we_data_q[i], i * 4, exp_data[i]);
         else pass_cnt++;
      end
      // Back in IDLE: a command byte must now be dispatched, not loaded
      send_byte(8'h09);
      idle(4);
      total_cnt++;
      if (mode_step !== 1'b1 || we_addr_q.size() !== 3) $display("FAIL load_exit_idle got=%b/%0d exp=1/3", mode_step, we_addr_q.size());
      else pass_cnt++;
      send_byte(8'h08);
      idle(3);
   endtask

   task automatic test_load_max();
      logic [7:0] i8;
      we_addr_q.delete(); we_data_q.delete();
      send_byte(8'h02);
      idle(2);
      for (int i = 0; i < 64; i++) begin
         i8 = 8'(i);
         send_byte(i8 + 8'h10);
         send_byte(8'hA5);
         send_byte(i8);
         send_byte(8'h5A);
      end
      send_byte(8'h09);
      idle(4);
      total_cnt++;
      if (we_addr_q.size() !== 64) $display("FAIL load_max_count got=%0d exp=64", we_addr_q.size());
      else pass_cnt++;
      total_cnt++;
      if (we_addr_q.size() != 64 || we_addr_q[63] !== 32'd252 || we_data_q[63] !== 32'h5A3FA54F)
         $display("FAIL load_max_last got=%0d words exp=64 ending 252:5A3FA54F", we_addr_q.size());
      else pass_cnt++;
      total_cnt++;
      if (mode_step !== 1'b1) $display("FAIL load_max_autoexit got=%b exp=1", mode_step);
      else pass_cnt++;
      send_byte(8'h08);
      idle(3);
   endtask

   task automatic test_step();
      send_byte(8'h09);
      send_byte(8'h0D);
      idle(4);
      total_cnt++;
      if (run !== 1'b0 || mode_step !== 1'b1) $display("FAIL step_mode_run got=%b%b exp=01", run, mode_step);
      else pass_cnt++;
      step_cnt = 0;
      for (int i = 0; i < 3; i++) send_byte(8'h0A);
      idle(4);
      total_cnt++;
      if (step_cnt !== 3) $display("FAIL step_pulses got=%0d exp=3", step_cnt);
      else pass_cnt++;
      @(posedge i_clk); #1 halt = 1'b1;
      @(posedge i_clk); #1 halt = 1'b0;
      idle(2);
      send_byte(8'h0A);
      idle(4);
      total_cnt++;
      if (step_cnt !== 3) $display("FAIL step_not_running got=%0d exp=3", step_cnt);
      else pass_cnt++;
   endtask

   task automatic test_halt();
      send_byte(8'h08);
      send_byte(8'h0D);
      idle(5);
      total_cnt++;
      if (run !== 1'b1) $display("FAIL halt_pre_run got=%b exp=1", run);
      else pass_cnt++;
      halt = 1'b1;
      @(posedge i_clk); #1 halt = 1'b0;
      total_cnt++;
      if (run !== 1'b0) $display("FAIL halt_stops_run got=%b exp=0", run);
      else pass_cnt++;
      idle(3);
   endtask

   task automatic test_latch_dump();
      logic [135:0] exp_v;
      logic [7:0]   exp_b;
      id_ex = {1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210};
      exp_v = {7'b0, id_ex};
      tx_q.delete();
      send_byte(8'h05);
      for (int c = 0; c < 300 && tx_q.size() < 3; c++) @(posedge i_clk);
      id_ex = '0;
      wait_bytes(17, 400);
      total_cnt++;
      if (tx_q.size() !== 17) $display("FAIL idex_count got=%0d exp=17", tx_q.size());
      else pass_cnt++;
      for (int k = 0; k < 17 && k < tx_q.size(); k++) begin
         exp_b = exp_v[8*k +: 8];
         total_cnt++;
         if (tx_q[k] !== exp_b) $display("FAIL idex_byte%0d got=%h exp=%h", k, tx_q[k], exp_b);
         else pass_cnt++;
      end
      total_cnt++;
      if (tx_q.size() != 17 || tx_q[16] !== 8'h01 || tx_q[0] !== 8'h10)
         $display("FAIL idex_ends got=%0d bytes exp=17 first=10 last=01", tx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b;
      logic [7:0] ifid_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      if_id = 32'hDEADBEEF;
      tx_q.delete();
      send_byte(8'h03);
      send_byte(8'h04);
      wait_bytes(132, 3000);
      total_cnt++;
      if (tx_q.size() !== 132) $display("FAIL queued_count got=%0d exp=132", tx_q.size());
      else pass_cnt++;
      for (int k = 0; k < 132 && k < tx_q.size(); k++) begin
         exp_b = (k < 128) ? 8'(k / 4) : ifid_b[k - 128];
         total_cnt++;
         if (tx_q[k] !== exp_b) $display("FAIL queued_byte%0d got=%h exp=%h", k, tx_q[k], exp_b);
         else pass_cnt++;
      end
   endtask

   task automatic test_overflow();
      logic [7:0] memwb_b [9] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h4A};
      logic [7:0] ifid_b [4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      logic [7:0] exp_b;
      mem_wb = {7'h4A, 64'h1122334455667788};
      tx_q.delete();
      send_byte(8'h07);
      for (int i = 0; i < 6; i++) send_byte(8'h04);
      wait_bytes(25, 1000);
      idle(200);
      total_cnt++;
      if (tx_q.size() !== 25) $display("FAIL overflow_count got=%0d exp=25", tx_q.size());
      else pass_cnt++;
      for (int k = 0; k < 25 && k < tx_q.size(); k++) begin
         exp_b = (k < 9) ? memwb_b[k] : ifid_b[(k - 9) % 4];
         total_cnt++;
         if (tx_q[k] !== exp_b) $display("FAIL overflow_byte%0d got=%h exp=%h", k, tx_q[k], exp_b);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_dump();
      int n_at_rst;
      tx_q.delete();
      send_byte(8'h03);
      for (int c = 0; c < 300 && tx_q.size() < 5; c++) @(posedge i_clk);
      #2 rst_n = 1'b0;
      n_at_rst = tx_q.size();
      #1;
      total_cnt++;
      if (tx_start !== 1'b0 || run !== 1'b0 || reg_addr !== 5'd0) $display("FAIL rst_mid_outputs got=%b%b/%0d exp=00/0", tx_start, run, reg_addr);
      else pass_cnt++;
      total_cnt++;
      if (n_at_rst < 5) $display("FAIL rst_mid_started got=%0d exp>=5", n_at_rst);
      else pass_cnt++;
      idle(3);
      rst_n = 1'b1;
      idle(200);
      total_cnt++;
      if (tx_q.size() !== n_at_rst) $display("FAIL rst_mid_no_tx got=%0d exp=%0d", tx_q.size(), n_at_rst);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mode();
      test_load();
      test_load_max();
      test_step();
      test_halt();
      test_latch_dump();
      test_back_to_back();
      test_overflow();
      test_reset_mid_dump();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
